// File: rtl/param_seq_det_pkg.sv
// seqdet_pkg: FSM state encoding and reset configuration for param_seq_det
package seqdet_pkg;
  typedef enum logic [1:0] {FILL, SEARCH, HIT} state_e;
  localparam logic [3:0] RST_PATTERN = 4'b0110;
  localparam int         RST_LEN     = 4;
  localparam logic       RST_OVERLAP = 1'b1;
endpackage

// File: rtl/param_seq_det_if.sv
// param_seq_det_if: serial data, configuration and result bundle of param_seq_det
interface param_seq_det_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) ();
  localparam int LW = $clog2(MAX_LEN + 1);
  logic               en;
  logic               data_in;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      pat_len;
  logic               overlap;
  logic               clr_cnt;
  logic               data_out;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_cnt;
  modport master (
    output en, data_in, cfg_load, pattern, pat_len, overlap, clr_cnt,
    input  data_out, cfg_err, match_cnt
  );
  modport slave (
    input  en, data_in, cfg_load, pattern, pat_len, overlap, clr_cnt,
    output data_out, cfg_err, match_cnt
  );
endinterface

// File: rtl/param_seq_det_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that beats increment
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // clear first, otherwise count up and stick at all-ones
  always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  // counter register, active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/param_seq_det.sv
// param_seq_det: configurable serial pattern detector; SEQDET_MATCH_CNT_EN builds in the match counter
module param_seq_det
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            rst,
  param_seq_det_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, pattern_q, pattern_d;
  logic [MAX_LEN-1:0] mask, hist_base, hist_sh;
  logic [LW-1:0]      fill_q, fill_d, len_q, len_d, fill_base, fill_sh;
  logic               overlap_q, overlap_d;
  logic               cfg_err, drop, match, hit;
  assign cfg_err = (len_q == '0) || (int'(len_q) > MAX_LEN);
  // low len_q bits of the history take part in the comparison
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
  end
  // shift candidate: non-overlapping mode restarts from an empty history after a hit
  always_comb begin
    drop      = (state_q == HIT) && !overlap_q;
    hist_base = drop ? '0 : hist_q;
    fill_base = drop ? '0 : fill_q;
    hist_sh   = {hist_base[MAX_LEN-2:0], bus.data_in};
    fill_sh   = (fill_base < len_q) ? fill_base + LW'(1) : fill_base;
    match     = !cfg_err && (fill_sh >= len_q) && (((hist_sh ^ pattern_q) & mask) == '0);
    hit       = bus.en && !bus.cfg_load && match;
  end
  // next state: a load wins over data, an illegal config parks the FSM in FILL
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    if (bus.cfg_load) begin
      pattern_d = bus.pattern;
      len_d     = bus.pat_len;
      overlap_d = bus.overlap;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = FILL;
    end else if (cfg_err) begin
      state_d = FILL;
    end else if (bus.en) begin
      hist_d  = hist_sh;
      fill_d  = fill_sh;
      state_d = match ? HIT : (fill_sh >= len_q) ? SEARCH : FILL;
    end
  end
  // state and shadow configuration registers, active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= MAX_LEN'(RST_PATTERN);
      len_q     <= LW'(RST_LEN);
      overlap_q <= RST_OVERLAP;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
    end
  end
  assign bus.data_out = (state_q == HIT);
  assign bus.cfg_err  = cfg_err;
`ifdef SEQDET_MATCH_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(bus.clr_cnt),
    .cnt(bus.match_cnt)
  );
`else
  logic unused_cnt;
  assign unused_cnt    = ^{bus.clr_cnt, hit};
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: doc/param_seq_det.md
PARAM_SEQ_DET -- requirements
Module: param_seq_det

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 16: width of the match counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low; asserted when 0, sampled on rising clk.
REQ-005 en  input  1  bit-valid qualifier; data_in is consumed only on a clock edge with en=1.
REQ-006 data_in  input  1  serial input bit.
REQ-007 cfg_load  input  1  strobe that latches pattern, pat_len and overlap into the shadow configuration.
REQ-008 pattern  input  MAX_LEN  target sequence; bit pat_len-1 is the first bit received and bit 0 is the last.
REQ-009 pat_len  input  $clog2(MAX_LEN+1)  active pattern length.
REQ-010 overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-011 clr_cnt  input  1  synchronous clear of match_cnt.
REQ-012 data_out  output  1  Moore detect flag.
REQ-013 cfg_err  output  1  latched configuration is illegal.
REQ-014 match_cnt  output  CNT_W  count of detections.

Function
REQ-015 The FSM SHALL have three states: FILL (fewer than len valid history bits), SEARCH (history full, no match), and HIT (a match was detected on the last consumed bit).
REQ-016 data_out SHALL equal (state==HIT), decoded from the state register only, with no combinational path from data_in.
REQ-017 The block SHALL keep an MAX_LEN-bit history shift register and a fill counter; each en=1 edge shifts data_in in at bit 0 and increments fill, saturating at len.
REQ-018 A match SHALL occur when, after the shift, fill ≥ len and history[len-1:0] equals pattern_q[len-1:0]; the next state is then HIT.
REQ-019 Latency: data_out SHALL rise during the cycle immediately after the edge that consumes the last pattern bit.
REQ-020 On en=0 edges the state, history and fill SHALL hold, so data_out stays at its current value.
REQ-021 In HIT with overlap_q=1, the next en=1 bit SHALL be evaluated against the retained history, allowing back-to-back hits.
REQ-022 In HIT with overlap_q=0, history and fill SHALL be discarded; the next en=1 bit becomes fill=1 in FILL.
REQ-023 On a cfg_load edge, the block SHALL latch the configuration, clear history and fill, and force FILL; data_in is not consumed on that edge, even if en=1.
REQ-024 cfg_err SHALL be 1 when pat_len_q==0 or pat_len_q>MAX_LEN; while cfg_err=1, the FSM SHALL stay in FILL and data_out SHALL stay 0.
REQ-025 match_cnt SHALL increment on every transition into HIT and SHALL saturate at 2^CNT_W-1.
REQ-026 If clr_cnt=1 on the same edge as a hit, match_cnt SHALL become 0; clear wins.

Reset
REQ-027 With rst=0 at a rising edge: state=FILL, history=0, fill=0, data_out=0, match_cnt=0.
REQ-028 Reset SHALL load pattern_q=4'b0110 zero-extended, pat_len_q=4, overlap_q=1, so cfg_err=0.
REQ-029 Reset SHALL take priority over cfg_load, clr_cnt and en, including in the middle of a sequence.

Configuration
REQ-030 The macro SEQDET_MATCH_CNT_EN SHALL control the counter: when defined, the counter and clr_cnt logic are compiled in per REQ-025/026.
REQ-031 When SEQDET_MATCH_CNT_EN is undefined, match_cnt SHALL be tied to 0, clr_cnt SHALL be ignored, and all other behaviour SHALL be unchanged.

Structure
REQ-032 The package seqdet_pkg SHALL hold the state enum (FILL, SEARCH, HIT) and the reset-pattern constants.
REQ-033 The counter SHALL be a sub-module, sat_counter (CNT_W, inc, clr); it is instantiated only under SEQDET_MATCH_CNT_EN.

Verification
REQ-034 Case 1: after reset, feed 0,1,1,0,1,1,0 with overlap=1 -> data_out=1 after the 4th and 7th bits; match_cnt=2.
REQ-035 Case 2: load the same pattern with overlap=0 and feed the same stream -> data_out=1 after the 4th bit only; match_cnt=1.
REQ-036 Case 3: load pattern 101, len=3, overlap=1; feed 1,0,1, hold en=0 for 3 cycles, then feed 0,1 -> data_out held at 1 through the stall, then 0, then 1 again; match_cnt=2.
REQ-037 Case 4: cfg_load with pat_len=0 and pat_len=MAX_LEN+1 -> cfg_err=1 and no hits on any stream; then a legal load -> cfg_err=0.
REQ-038 Case 5: assert rst=0 mid-pattern (after 0,1,1), then feed 0 -> no hit; counter 0 and state FILL.
REQ-039 Case 6: set CNT_W=2, produce 5 hits with clr_cnt pulsed on the 5th -> match_cnt saturates at 3, then reads 0; rebuild without the macro -> match_cnt stays 0.
